// File: rtl/ins_fetch.sv
// Instruction fetch: reads 1-2 ROM words at pc, decodes, issues one work strobe.
// Latency from ready edge E: work after E+ROM_LAT+2 (one word) / E+2*ROM_LAT+4 (two words); no reissue until ready drops.
module ins_fetch #(
  parameter int ADDR_W  = 15,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ready,
  input  logic              flush,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [15:0]       rom_data,
  output logic [4:0]        exe,
  output logic [1:0]        ereg1,
  output logic [1:0]        ereg2,
  output logic [15:0]       edata,
  output logic              work,
  output logic              busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD0   = 3'd1;
  localparam logic [2:0] S_WT0   = 3'd2;
  localparam logic [2:0] S_RD1   = 3'd3;
  localparam logic [2:0] S_WT1   = 3'd4;
  localparam logic [2:0] S_ISSUE = 3'd5;
  localparam logic [2:0] S_HOLD  = 3'd6;

  localparam logic [2:0] LAT_W0 = 3'(ROM_LAT);
  // Word 1 strobes from RD1 rather than WT0, so its wait runs one cycle longer.
  localparam logic [2:0] LAT_W1 = 3'(ROM_LAT + 1);

  logic [2:0]        state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [15:0]       word0;
  logic [15:0]       word1;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      base     <= '0;
      word0    <= '0;
      word1    <= '0;
      rom_addr <= '0;
      rom_rd   <= 1'b0;
      exe      <= '0;
      ereg1    <= '0;
      ereg2    <= '0;
      edata    <= '0;
      work     <= 1'b0;
    end else begin
      rom_rd <= 1'b0;
      work   <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (ready) begin
              base     <= pc;
              rom_addr <= pc;
              rom_rd   <= 1'b1;
              state    <= S_RD0;
            end
          end
          S_RD0: begin
            cnt   <= LAT_W0;
            state <= S_WT0;
          end
          S_WT0: begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              word0 <= rom_data;
              if (rom_data[6]) begin
                rom_addr <= base + 1'b1;
                state    <= S_RD1;
              end else begin
                state <= S_ISSUE;
              end
            end
          end
          S_RD1: begin
            rom_rd <= 1'b1;
            cnt    <= LAT_W1;
            state  <= S_WT1;
          end
          S_WT1: begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) begin
              word1 <= rom_data;
              state <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            exe   <= word0[15:11];
            ereg1 <= word0[10:9];
            ereg2 <= word0[8:7];
            edata <= word0[6] ? word1 : {10'd0, word0[5:0]};
            work  <= 1'b1;
            state <= S_HOLD;
          end
          S_HOLD: begin
            // Core still reports idle right after issue; wait for it to drop.
            if (!ready) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: directed fetches, monitor checks ROM reads and issued instructions.
module tb_ins_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] pc;
  logic        ready;
  logic        flush;
  logic [14:0] rom_addr;
  logic        rom_rd;
  logic [15:0] rom_data;
  logic [4:0]  exe;
  logic [1:0]  ereg1;
  logic [1:0]  ereg2;
  logic [15:0] edata;
  logic        work;
  logic        busy;

  ins_fetch #(.ADDR_W(15), .ROM_LAT(1)) dut (
    .clk(clk), .rst(rst), .pc(pc), .ready(ready), .flush(flush),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .exe(exe), .ereg1(ereg1), .ereg2(ereg2), .edata(edata),
    .work(work), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:32767];
  always @(posedge clk) rom_data <= rom_rd ? mem[rom_addr] : 16'hA5A5;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [24:0] dec;
    int          at;
  } exp_t;

  exp_t        exp_q [$];
  logic [14:0] addr_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic expect_ins(input logic [4:0] e, input logic [1:0] r1, input logic [1:0] r2,
                            input logic [15:0] d, input int at);
    exp_t x;
    x.dec = {e, r1, r2, d};
    x.at  = at;
    exp_q.push_back(x);
  endtask

  task automatic pulse_ready(input logic [14:0] p, output int e);
    @(negedge clk);
    pc    = p;
    ready = 1'b1;
    e     = cyc + 1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  exp_t        mon_x;
  logic [14:0] mon_a;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rom_rd) begin
        if (addr_q.size() == 0) check("unexpected_rom_rd", {49'd0, rom_addr}, 64'h7FFF_FFFF);
        else begin
          mon_a = addr_q.pop_front();
          check("rom_addr", {49'd0, rom_addr}, {49'd0, mon_a});
        end
      end
      if (work) begin
        if (exp_q.size() == 0) check("unexpected_work", {32'd0, cyc}, 64'hFFFF_FFFF);
        else begin
          mon_x = exp_q.pop_front();
          check("issue", {7'd0, exe, ereg1, ereg2, edata, cyc}, {7'd0, mon_x.dec, mon_x.at});
        end
      end
    end
  end

  int e;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[15'h0010] = 16'h1C85;
    mem[15'h0020] = 16'h1CC0;
    mem[15'h0021] = 16'hBEEF;
    mem[15'h7FFF] = 16'h4BC0;
    mem[15'h0000] = 16'h1234;
    mem[15'h0030] = 16'h1C85;
    mem[15'h0040] = 16'h0A3F;
    mem[15'h0050] = 16'h2101;
    mem[15'h0060] = 16'hFFBF;

    rst = 1'b0; pc = '0; ready = 1'b0; flush = 1'b0;
    #1;
    check("reset_state", {21'd0, work, rom_rd, rom_addr, exe, ereg1, ereg2, edata, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // single-word fetch
    addr_q.push_back(15'h0010);
    pulse_ready(15'h0010, e);
    expect_ins(5'd3, 2'd2, 2'd1, 16'h0005, e + 3);
    repeat (8) @(negedge clk);

    // two-word fetch
    addr_q.push_back(15'h0020);
    addr_q.push_back(15'h0021);
    pulse_ready(15'h0020, e);
    expect_ins(5'd3, 2'd2, 2'd1, 16'hBEEF, e + 6);
    repeat (10) @(negedge clk);

    // second word address wraps to 0
    addr_q.push_back(15'h7FFF);
    addr_q.push_back(15'h0000);
    pulse_ready(15'h7FFF, e);
    expect_ins(5'd9, 2'd1, 2'd3, 16'h1234, e + 6);
    repeat (10) @(negedge clk);

    // flush during WT0 drops the fetch
    addr_q.push_back(15'h0030);
    pulse_ready(15'h0030, e);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {63'd0, busy}, 64'd0);
    check("flush_keeps_decode", {43'd0, exe, edata}, {43'd0, 5'd9, 16'h1234});
    repeat (4) @(negedge clk);

    // flush beats ready in IDLE
    flush = 1'b1; ready = 1'b1; pc = 15'h0030;
    @(negedge clk);
    flush = 1'b0; ready = 1'b0;
    check("flush_wins_idle", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);

    addr_q.push_back(15'h0040);
    pulse_ready(15'h0040, e);
    expect_ins(5'd1, 2'd1, 2'd0, 16'h003F, e + 3);
    repeat (8) @(negedge clk);

    // ready held high: one issue, pc change mid-fetch ignored
    addr_q.push_back(15'h0050);
    @(negedge clk);
    pc = 15'h0050; ready = 1'b1; e = cyc + 1;
    expect_ins(5'd4, 2'd0, 2'd2, 16'h0001, e + 3);
    @(negedge clk);
    pc = 15'h0060;
    repeat (10) @(negedge clk);
    check("hold_busy", {63'd0, busy}, 64'd1);
    ready = 1'b0;
    @(negedge clk);
    ready = 1'b1; e = cyc + 1;
    addr_q.push_back(15'h0060);
    expect_ins(5'd31, 2'd3, 2'd3, 16'h003F, e + 3);
    repeat (6) @(negedge clk);
    ready = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset mid-WT1
    addr_q.push_back(15'h0020);
    addr_q.push_back(15'h0021);
    pulse_ready(15'h0020, e);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset", {21'd0, work, rom_rd, rom_addr, exe, ereg1, ereg2, edata, busy}, 64'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_no_issue", {63'd0, busy}, 64'd0);

    addr_q.push_back(15'h0010);
    pulse_ready(15'h0010, e);
    expect_ins(5'd3, 2'd2, 2'd1, 16'h0005, e + 3);
    repeat (10) @(negedge clk);

    check("pending_issues", {32'd0, 32'(exp_q.size())}, 64'd0);
    check("pending_reads", {32'd0, 32'(addr_q.size())}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
